// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes A - B one bit per clock, LSB first, through a
// full-subtractor cell with a registered borrow, behind a Start/Busy/Done handshake.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic             Borrow_Out,
    output logic             Overflow,
    output logic [1:0]       o_dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_borrow;

    // Handshake: Start is accepted only in IDLE or DONE; once accepted, Busy stays
    // high for WIDTH cycles, then Done pulses for one cycle with the result valid.
    // Start seen while Busy is ignored.
    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_d      = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow = (~r_a[0] & r_b[0]) | (~r_a[0] & r_borrow) | (r_b[0] & r_borrow);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_out    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_a_msb  <= A[WIDTH-1];
            r_b_msb  <= B[WIDTH-1];
        end else if (r_state == S_RUN) begin
            // Difference bits enter at the top so the LSB lands in bit 0 after WIDTH shifts.
            r_out    <= {w_d, r_out[WIDTH-1:1]};
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_borrow <= w_borrow;
            r_count  <= r_count + CW'(1);
        end
    end

    assign Busy        = (r_state == S_RUN);
    assign Done        = (r_state == S_DONE);
    assign Out         = r_out;
    assign Borrow_Out  = r_borrow;
    assign Overflow    = (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_out[WIDTH-1]);
    assign o_dbg_state = r_state;
endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial unsigned/two's-complement subtractor that computes A − B one bit per clock, LSB first, using the full-subtractor cell equations with a registered borrow. It sits directly upstream of the full-subtractor cell and drives it: it holds the operand shift registers, feeds one bit pair plus the stored borrow each cycle, and captures the cell's difference and borrow outputs. It trades the area of a WIDTH-bit ripple subtractor for WIDTH cycles of latency and exposes a Start/Busy/Done handshake to the controlling logic.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2–32.

- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend, captured on the accepting edge.
- B  input  WIDTH  subtrahend, captured on the accepting edge.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse; Out, Borrow_Out and Overflow are valid.
- Out  output  WIDTH  difference A − B mod 2^WIDTH.
- Borrow_Out  output  1  final borrow; 1 iff A < B unsigned.
- Overflow  output  1  signed overflow of A − B.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: Start=1 → load A_Reg←A, B_Reg←B, Borrow_Reg←0, Count←0, Out_Reg←0, latch A[WIDTH-1], B[WIDTH-1] → RUN. Start=0 → stay.
- RUN, each cycle, with a=A_Reg[0], b=B_Reg[0], c=Borrow_Reg:
  - d = a ^ b ^ c; borrow = (~a & b) | (~a & c) | (b & c).
  - Out_Reg shifts right, d enters at bit WIDTH-1.
  - A_Reg and B_Reg shift right, zero fill.
  - Borrow_Reg←borrow; Count←Count+1.
  - Count = WIDTH-1 at the edge → DONE.
- DONE, one cycle:
  - Done=1.
  - Out=Out_Reg; Borrow_Out=Borrow_Reg.
  - Overflow = (A_msb ^ B_msb) & (A_msb ^ Out_Reg[WIDTH-1]).
  - Start=1 → reload as in IDLE → RUN (back-to-back). Start=0 → IDLE.
- Start while in RUN is ignored. A and B are don't-care outside the accepting edge.
- Out, Borrow_Out and Overflow hold their last result through IDLE until the next accepting edge. They may show partial values while Busy=1; consumers sample them only on Done.
- Count width is clog2(WIDTH)+1 bits; no wrap occurs within an operation.

## Timing
- Reset values: Busy=0, Done=0, Out=0, Borrow_Out=0, Overflow=0, state IDLE, Count=0.
- Reset wins over every other condition, including mid-RUN: the operation is aborted and no Done is produced.
- Start accepted at edge k → Busy=1 during cycles k+1 … k+WIDTH.
- Done=1 during cycle k+WIDTH+1, with Busy=0.
- Latency from accepting edge to Done: WIDTH+1 cycles.
- Back-to-back throughput: one result every WIDTH+1 cycles.
- Busy and Done are never high together. Done is never high for two consecutive cycles unless there is a back-to-back restart with WIDTH=… (not possible: at least WIDTH RUN cycles separate Done pulses).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, A=0x5A, B=0x33, Start pulse → after 8 Busy cycles, Done with Out=0x27, Borrow_Out=0, Overflow=0.
- A=0x10, B=0x20 → Out=0xF0, Borrow_Out=1, Overflow=0. Then A=0x00, B=0x01 → Out=0xFF, Borrow_Out=1.
- A=0x80, B=0x01 → Out=0x7F, Borrow_Out=0, Overflow=1. Then A=0xAA, B=0xAA → Out=0x00, Borrow_Out=0, Overflow=0.
- Start=1 held high continuously with new operands each Done cycle → Done pulses exactly every 9 cycles with correct results. Start pulses injected mid-RUN → no effect.
- Reset asserted in the 4th RUN cycle → next cycle Busy=0, Done=0, Out=0, Borrow_Out=0. No Done follows. A fresh Start then completes normally.
- Random A/B, 1000 operations, WIDTH=8 and WIDTH=32 → Out equals (A−B) mod 2^WIDTH and Borrow_Out equals (A<B) against a scoreboard.
